// File: rtl/tow_game_ctrl.sv
// Tug-of-war game controller: edge-detects the buttons and sequences IDLE/READY/PLAY/WIN/FOUL.
// Optional per-player win tallies are built only when TOW_WIN_COUNT_EN is defined.
module tow_game_ctrl #(
    parameter int READY_CYCLES = 50000000,
    parameter int FLASH_CYCLES = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       btn_l,
    input  logic       btn_r,
    output logic [1:0] led_control,
    output logic [6:0] score,
    output logic [1:0] winner,
    output logic [3:0] wins_l,
    output logic [3:0] wins_r
);

    localparam logic [6:0]  CENTER     = 7'b0001000;
    localparam logic [6:0]  LEFT_GOAL  = 7'b1000000;
    localparam logic [6:0]  RIGHT_GOAL = 7'b0000001;
    localparam logic [31:0] READY_LOAD = 32'(READY_CYCLES - 1);
    localparam logic [31:0] FLASH_LOAD = 32'(FLASH_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READY = 3'd1,
        PLAY  = 3'd2,
        WIN   = 3'd3,
        FOUL  = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic        start_q_r, btn_l_q_r, btn_r_q_r;
    logic        start_press_s, l_press_s, r_press_s;
    logic [31:0] timer_r, timer_s;
    logic [1:0]  led_r, led_s;
    logic [6:0]  score_r, score_s;
    logic [1:0]  winner_r, winner_s;

    assign start_press_s = start & ~start_q_r;
    assign l_press_s     = btn_l & ~btn_l_q_r;
    assign r_press_s     = btn_r & ~btn_r_q_r;

    // State, timer, edge registers and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            start_q_r <= 1'b0;
            btn_l_q_r <= 1'b0;
            btn_r_q_r <= 1'b0;
            timer_r   <= 32'd0;
            led_r     <= 2'd0;
            score_r   <= CENTER;
            winner_r  <= 2'b00;
        end else begin
            state_r   <= state_s;
            start_q_r <= start;
            btn_l_q_r <= btn_l;
            btn_r_q_r <= btn_r;
            timer_r   <= timer_s;
            led_r     <= led_s;
            score_r   <= score_s;
            winner_r  <= winner_s;
        end
    end

    // Next-state and next-output logic; the output registers load the values of the next state
    always_comb begin
        state_s  = state_r;
        timer_s  = timer_r;
        led_s    = led_r;
        score_s  = score_r;
        winner_s = winner_r;
        case (state_r)
            IDLE: begin
                led_s   = 2'd0;
                score_s = CENTER;
                if (start_press_s) begin
                    state_s  = READY;
                    timer_s  = READY_LOAD;
                    winner_s = 2'b00;
                    led_s    = 2'd1;
                end else begin
                    state_s = IDLE;
                end
            end
            READY: begin
                led_s = 2'd1;
                // A foul press wins over timer expiry in the same cycle
                if (l_press_s || r_press_s) begin
                    state_s = FOUL;
                    led_s   = 2'd3;
                    if (l_press_s && r_press_s) begin
                        winner_s = 2'b00;
                    end else if (l_press_s) begin
                        winner_s = 2'b10;
                    end else begin
                        winner_s = 2'b01;
                    end
                end else if (timer_r == 32'd0) begin
                    state_s = PLAY;
                    led_s   = 2'd2;
                end else begin
                    timer_s = timer_r - 32'd1;
                end
            end
            PLAY: begin
                led_s = 2'd2;
                if (l_press_s && !r_press_s) begin
                    score_s = {score_r[5:0], 1'b0};
                end else if (r_press_s && !l_press_s) begin
                    score_s = {1'b0, score_r[6:1]};
                end else begin
                    score_s = score_r;
                end
                if (score_s == LEFT_GOAL) begin
                    state_s  = WIN;
                    winner_s = 2'b01;
                    timer_s  = FLASH_LOAD;
                end else if (score_s == RIGHT_GOAL) begin
                    state_s  = WIN;
                    winner_s = 2'b10;
                    timer_s  = FLASH_LOAD;
                end else begin
                    state_s = PLAY;
                end
            end
            WIN: begin
                if (start_press_s) begin
                    state_s  = READY;
                    score_s  = CENTER;
                    winner_s = 2'b00;
                    timer_s  = READY_LOAD;
                    led_s    = 2'd1;
                end else if (timer_r == 32'd0) begin
                    led_s   = (led_r == 2'd2) ? 2'd0 : 2'd2;
                    timer_s = FLASH_LOAD;
                end else begin
                    timer_s = timer_r - 32'd1;
                end
            end
            FOUL: begin
                led_s = 2'd3;
                if (start_press_s) begin
                    state_s  = READY;
                    score_s  = CENTER;
                    winner_s = 2'b00;
                    timer_s  = READY_LOAD;
                    led_s    = 2'd1;
                end else begin
                    state_s = FOUL;
                end
            end
            default: begin
                state_s  = IDLE;
                timer_s  = 32'd0;
                led_s    = 2'd0;
                score_s  = CENTER;
                winner_s = 2'b00;
            end
        endcase
    end

    assign led_control = led_r;
    assign score       = score_r;
    assign winner      = winner_r;

`ifdef TOW_WIN_COUNT_EN
    logic       win_entry_s;
    logic [3:0] tally_l_r, tally_r_r;

    assign win_entry_s = (state_s == WIN) && (state_r != WIN);

    // Saturating win tallies, bumped on the edge that enters WIN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tally_l_r <= 4'd0;
            tally_r_r <= 4'd0;
        end else begin
            if (win_entry_s && winner_s == 2'b01 && tally_l_r != 4'd15) begin
                tally_l_r <= tally_l_r + 4'd1;
            end else begin
                tally_l_r <= tally_l_r;
            end
            if (win_entry_s && winner_s == 2'b10 && tally_r_r != 4'd15) begin
                tally_r_r <= tally_r_r + 4'd1;
            end else begin
                tally_r_r <= tally_r_r;
            end
        end
    end

    assign wins_l = tally_l_r;
    assign wins_r = tally_r_r;
`else
    assign wins_l = 4'd0;
    assign wins_r = 4'd0;
`endif

endmodule

// File: tb/tb_tow_game_ctrl.sv
// Scoreboard bench for tow_game_ctrl with READY_CYCLES=4 and FLASH_CYCLES=3.
module tb_tow_game_ctrl;

    localparam logic [6:0] C = 7'b0001000;

    typedef struct packed {
        logic [1:0] led;
        logic [6:0] sc;
        logic [1:0] w;
        logic [3:0] wl;
        logic [3:0] wr;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       btn_l = 1'b0;
    logic       btn_r = 1'b0;
    logic [1:0] led_control;
    logic [6:0] score;
    logic [1:0] winner;
    logic [3:0] wins_l, wins_r;

    obs_t exp_q[$];
    obs_t obs_q[$];
    logic [3:0] ew_l = 4'd0;
    logic [3:0] ew_r = 4'd0;
    int total = 0;
    int passed = 0;

    tow_game_ctrl #(.READY_CYCLES(4), .FLASH_CYCLES(3)) dut (
        .clk(clk), .reset(reset), .start(start), .btn_l(btn_l), .btn_r(btn_r),
        .led_control(led_control), .score(score), .winner(winner),
        .wins_l(wins_l), .wins_r(wins_r)
    );

    always #5 clk = ~clk;

    task automatic bump_l();
`ifdef TOW_WIN_COUNT_EN
        if (ew_l != 4'd15) ew_l = ew_l + 4'd1;
`endif
    endtask

    task automatic bump_r();
`ifdef TOW_WIN_COUNT_EN
        if (ew_r != 4'd15) ew_r = ew_r + 4'd1;
`endif
    endtask

    // Drive one cycle of inputs, queue the expected outputs, record what the DUT shows after the edge
    task automatic apply(input logic s, input logic l, input logic r,
                         input logic [1:0] led, input logic [6:0] sc, input logic [1:0] w);
        start = s; btn_l = l; btn_r = r;
        exp_q.push_back(obs_t'({led, sc, w, ew_l, ew_r}));
        @(posedge clk); #1;
        obs_q.push_back(obs_t'({led_control, score, winner, wins_l, wins_r}));
    endtask

    task automatic test_reset();
        obs_t e, o;
        apply(1'b0, 1'b0, 1'b0, 2'd0, C, 2'b00);
        reset = 1'b0;
        apply(1'b0, 1'b0, 1'b0, 2'd0, C, 2'b00);
        apply(1'b0, 1'b1, 1'b1, 2'd0, C, 2'b00);
        apply(1'b0, 1'b0, 1'b0, 2'd0, C, 2'b00);
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) $display("FAIL reset[%0d]: got led=%0d score=%b winner=%b wins=%0d/%0d, want led=%0d score=%b winner=%b wins=%0d/%0d", i, o.led, o.sc, o.w, o.wl, o.wr, e.led, e.sc, e.w, e.wl, e.wr);
            else passed++;
        end
    endtask

    task automatic test_countdown();
        obs_t e, o;
        apply(1'b1, 1'b0, 1'b0, 2'd1, C, 2'b00);
        for (int k = 0; k < 3; k++) apply(1'b0, 1'b0, 1'b0, 2'd1, C, 2'b00);
        apply(1'b0, 1'b0, 1'b0, 2'd2, C, 2'b00);
        apply(1'b1, 1'b0, 1'b0, 2'd2, C, 2'b00);
        apply(1'b0, 1'b0, 1'b0, 2'd2, C, 2'b00);
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) $display("FAIL countdown[%0d]: got led=%0d score=%b winner=%b wins=%0d/%0d, want led=%0d score=%b winner=%b wins=%0d/%0d", i, o.led, o.sc, o.w, o.wl, o.wr, e.led, e.sc, e.w, e.wl, e.wr);
            else passed++;
        end
    endtask

    task automatic test_left_win_flash();
        obs_t e, o;
        apply(1'b0, 1'b1, 1'b0, 2'd2, 7'b0010000, 2'b00);
        apply(1'b0, 1'b0, 1'b0, 2'd2, 7'b0010000, 2'b00);
        apply(1'b0, 1'b1, 1'b0, 2'd2, 7'b0100000, 2'b00);
        apply(1'b0, 1'b0, 1'b0, 2'd2, 7'b0100000, 2'b00);
        bump_l();
        apply(1'b0, 1'b1, 1'b0, 2'd2, 7'b1000000, 2'b01);
        apply(1'b0, 1'b0, 1'b0, 2'd2, 7'b1000000, 2'b01);
        apply(1'b0, 1'b0, 1'b1, 2'd2, 7'b1000000, 2'b01);
        apply(1'b0, 1'b0, 1'b0, 2'd0, 7'b1000000, 2'b01);
        apply(1'b0, 1'b1, 1'b0, 2'd0, 7'b1000000, 2'b01);
        apply(1'b0, 1'b0, 1'b0, 2'd0, 7'b1000000, 2'b01);
        for (int k = 0; k < 3; k++) apply(1'b0, 1'b0, 1'b0, 2'd2, 7'b1000000, 2'b01);
        apply(1'b0, 1'b0, 1'b0, 2'd0, 7'b1000000, 2'b01);
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) $display("FAIL left_win[%0d]: got led=%0d score=%b winner=%b wins=%0d/%0d, want led=%0d score=%b winner=%b wins=%0d/%0d", i, o.led, o.sc, o.w, o.wl, o.wr, e.led, e.sc, e.w, e.wl, e.wr);
            else passed++;
        end
    endtask

    task automatic test_foul();
        obs_t e, o;
        apply(1'b1, 1'b0, 1'b0, 2'd1, C, 2'b00);
        apply(1'b0, 1'b0, 1'b0, 2'd1, C, 2'b00);
        apply(1'b0, 1'b0, 1'b1, 2'd3, C, 2'b01);
        apply(1'b0, 1'b0, 1'b0, 2'd3, C, 2'b01);
        apply(1'b0, 1'b1, 1'b0, 2'd3, C, 2'b01);
        apply(1'b1, 1'b0, 1'b0, 2'd1, C, 2'b00);
        apply(1'b1, 1'b0, 1'b0, 2'd1, C, 2'b00);
        apply(1'b0, 1'b0, 1'b0, 2'd1, C, 2'b00);
        apply(1'b0, 1'b0, 1'b0, 2'd1, C, 2'b00);
        apply(1'b0, 1'b1, 1'b0, 2'd3, C, 2'b10);
        apply(1'b0, 1'b0, 1'b0, 2'd3, C, 2'b10);
        apply(1'b1, 1'b0, 1'b0, 2'd1, C, 2'b00);
        apply(1'b0, 1'b1, 1'b1, 2'd3, C, 2'b00);
        apply(1'b1, 1'b0, 1'b0, 2'd1, C, 2'b00);
        for (int k = 0; k < 3; k++) apply(1'b0, 1'b0, 1'b0, 2'd1, C, 2'b00);
        apply(1'b0, 1'b0, 1'b0, 2'd2, C, 2'b00);
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) $display("FAIL foul[%0d]: got led=%0d score=%b winner=%b wins=%0d/%0d, want led=%0d score=%b winner=%b wins=%0d/%0d", i, o.led, o.sc, o.w, o.wl, o.wr, e.led, e.sc, e.w, e.wl, e.wr);
            else passed++;
        end
    endtask

    task automatic test_simultaneous_and_hold();
        obs_t e, o;
        apply(1'b0, 1'b1, 1'b1, 2'd2, C, 2'b00);
        apply(1'b0, 1'b0, 1'b0, 2'd2, C, 2'b00);
        for (int k = 0; k < 10; k++) apply(1'b0, 1'b1, 1'b0, 2'd2, 7'b0010000, 2'b00);
        apply(1'b0, 1'b0, 1'b0, 2'd2, 7'b0010000, 2'b00);
        apply(1'b0, 1'b0, 1'b1, 2'd2, C, 2'b00);
        apply(1'b0, 1'b0, 1'b0, 2'd2, C, 2'b00);
        apply(1'b0, 1'b0, 1'b1, 2'd2, 7'b0000100, 2'b00);
        apply(1'b0, 1'b0, 1'b0, 2'd2, 7'b0000100, 2'b00);
        apply(1'b0, 1'b0, 1'b1, 2'd2, 7'b0000010, 2'b00);
        apply(1'b0, 1'b0, 1'b0, 2'd2, 7'b0000010, 2'b00);
        bump_r();
        apply(1'b0, 1'b0, 1'b1, 2'd2, 7'b0000001, 2'b10);
        apply(1'b0, 1'b0, 1'b0, 2'd2, 7'b0000001, 2'b10);
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) $display("FAIL simul_hold[%0d]: got led=%0d score=%b winner=%b wins=%0d/%0d, want led=%0d score=%b winner=%b wins=%0d/%0d", i, o.led, o.sc, o.w, o.wl, o.wr, e.led, e.sc, e.w, e.wl, e.wr);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_play();
        obs_t e, o;
        apply(1'b1, 1'b0, 1'b0, 2'd1, C, 2'b00);
        for (int k = 0; k < 3; k++) apply(1'b0, 1'b0, 1'b0, 2'd1, C, 2'b00);
        apply(1'b0, 1'b0, 1'b0, 2'd2, C, 2'b00);
        apply(1'b0, 1'b1, 1'b0, 2'd2, 7'b0010000, 2'b00);
        apply(1'b0, 1'b0, 1'b0, 2'd2, 7'b0010000, 2'b00);
        apply(1'b0, 1'b1, 1'b0, 2'd2, 7'b0100000, 2'b00);
        // Assert reset between edges: outputs must drop without waiting for a clock
        #2;
        reset = 1'b1;
        ew_l = 4'd0; ew_r = 4'd0;
        exp_q.push_back(obs_t'({2'd0, C, 2'b00, 4'd0, 4'd0}));
        #1;
        obs_q.push_back(obs_t'({led_control, score, winner, wins_l, wins_r}));
        @(posedge clk); #1;
        reset = 1'b0;
        apply(1'b0, 1'b0, 1'b0, 2'd0, C, 2'b00);
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) $display("FAIL reset_mid_play[%0d]: got led=%0d score=%b winner=%b wins=%0d/%0d, want led=%0d score=%b winner=%b wins=%0d/%0d", i, o.led, o.sc, o.w, o.wl, o.wr, e.led, e.sc, e.w, e.wl, e.wr);
            else passed++;
        end
    endtask

    task automatic test_back_to_back_tally();
        obs_t e, o;
        for (int g = 0; g < 16; g++) begin
            apply(1'b1, 1'b0, 1'b0, 2'd1, C, 2'b00);
            for (int k = 0; k < 3; k++) apply(1'b0, 1'b0, 1'b0, 2'd1, C, 2'b00);
            apply(1'b0, 1'b0, 1'b0, 2'd2, C, 2'b00);
            apply(1'b0, 1'b0, 1'b1, 2'd2, 7'b0000100, 2'b00);
            apply(1'b0, 1'b0, 1'b0, 2'd2, 7'b0000100, 2'b00);
            apply(1'b0, 1'b0, 1'b1, 2'd2, 7'b0000010, 2'b00);
            apply(1'b0, 1'b0, 1'b0, 2'd2, 7'b0000010, 2'b00);
            bump_r();
            apply(1'b0, 1'b0, 1'b1, 2'd2, 7'b0000001, 2'b10);
            apply(1'b0, 1'b0, 1'b0, 2'd2, 7'b0000001, 2'b10);
        end
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) $display("FAIL tally[%0d]: got led=%0d score=%b winner=%b wins=%0d/%0d, want led=%0d score=%b winner=%b wins=%0d/%0d", i, o.led, o.sc, o.w, o.wl, o.wr, e.led, e.sc, e.w, e.wl, e.wr);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_left_win_flash();
        test_foul();
        test_simultaneous_and_hold();
        test_reset_mid_play();
        test_back_to_back_tally();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
